// File: rtl/bus_cmd_master_pkg.sv
// Shared bus constants and the command-master state enumeration.
package bus_cmd_master_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/bus_cmd_master.sv
// Single-outstanding bus command master: accepts a command, drives a bus
// request until the slave completes it or a wait limit expires, then holds
// the response until downstream takes it.
module bus_cmd_master
  import bus_cmd_master_pkg::*;
#(
  parameter int TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              valid,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  input  logic              ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_timeout,
  output logic [4:0]        txn_count
);

  // Last wait-counter value before the request is abandoned.
  localparam logic [3:0] WAIT_LAST = 4'(TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [3:0]          wait_q, wait_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_to_q, rsp_to_d;
  logic [4:0]          txn_q, txn_d;

  // Handshake-facing outputs are pure state decodes, so ready/rsp_ready
  // never reach an output combinationally.
  assign cmd_ready   = (state_q == IDLE);
  assign valid       = (state_q == REQ);
  assign rsp_valid   = (state_q == RESP);
  assign addr        = addr_q;
  assign wdata       = wdata_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_timeout = rsp_to_q;
  assign txn_count   = txn_q;

  // Next-state and datapath updates; bus inputs only matter while in REQ.
  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_to_d    = rsp_to_q;
    txn_d       = txn_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          wait_d  = 4'd0;
          state_d = REQ;
        end
      end
      REQ: begin
        // A completion on the final wait cycle still wins over the timeout.
        if (ready) begin
          rsp_rdata_d = rdata;
          rsp_to_d    = 1'b0;
          state_d     = RESP;
        end else if (wait_q == WAIT_LAST) begin
          rsp_rdata_d = '0;
          rsp_to_d    = 1'b1;
          state_d     = RESP;
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          txn_d   = txn_q + 5'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      wait_q      <= 4'd0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_rdata_q <= '0;
      rsp_to_q    <= 1'b0;
      txn_q       <= 5'd0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_to_q    <= rsp_to_d;
      txn_q       <= txn_d;
    end
  end

endmodule

// File: tb/tb_bus_cmd_master.sv
// Randomized bench for bus_cmd_master against a transaction-level model.
module tb_bus_cmd_master;

  localparam int TIMEOUT = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready;
  logic [3:0] cmd_addr, cmd_wdata;
  logic       valid;
  logic [3:0] addr, wdata, rdata;
  logic       ready;
  logic       rsp_valid, rsp_ready;
  logic [3:0] rsp_rdata;
  logic       rsp_timeout;
  logic [4:0] txn_count;

  int checks   = 0;
  int failures = 0;
  int exp_txn  = 0;
  int cyc      = 0;
  int last_acc = 0;

  bus_cmd_master #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .valid(valid), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ready(ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
    .txn_count(txn_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One transaction. The slave completes on REQ cycle index d (0-based);
  // d >= TIMEOUT means it never completes. Called at a negedge in IDLE.
  task automatic txn(input logic [3:0] a, input logic [3:0] w, input logic [3:0] rd,
                     input int d, input int hold, input bit chk_space);
    int n;
    bit exp_to;
    int exp_n;
    logic [3:0] exp_rd;
    exp_to = (d >= TIMEOUT);
    exp_n  = exp_to ? TIMEOUT : d + 1;
    exp_rd = exp_to ? 4'h0 : rd;

    chk("cmd_ready_idle", cmd_ready, 1);
    chk("valid_idle", valid, 0);
    if (chk_space) chk("cmd_spacing", cyc - last_acc, 3);
    last_acc  = cyc;
    cmd_valid = 1'b1; cmd_addr = a; cmd_wdata = w;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_addr = 4'($urandom); cmd_wdata = 4'($urandom);
    chk("valid_latency", valid, 1);
    n = 0;
    while (valid === 1'b1 && n < 20) begin
      chk("addr_stable", addr, a);
      chk("wdata_stable", wdata, w);
      chk("cmd_ready_req", cmd_ready, 0);
      chk("rsp_valid_req", rsp_valid, 0);
      ready = (n == d);
      rdata = (n == d) ? rd : 4'($urandom);
      n++;
      @(negedge clk);
    end
    chk("req_cycles", n, exp_n);
    // Bus noise outside REQ must have no effect.
    ready = 1'($urandom); rdata = 4'($urandom);
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_rdata", rsp_rdata, exp_rd);
    chk("rsp_timeout", rsp_timeout, exp_to);
    for (int h = 0; h < hold; h++) begin
      rsp_ready = 1'b0;
      @(negedge clk);
      ready = 1'($urandom); rdata = 4'($urandom);
      chk("hold_rsp_valid", rsp_valid, 1);
      chk("hold_rsp_rdata", rsp_rdata, exp_rd);
      chk("hold_rsp_timeout", rsp_timeout, exp_to);
      chk("hold_cmd_ready", cmd_ready, 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0; ready = 1'b0;
    exp_txn = (exp_txn + 1) % 32;
    chk("txn_count", txn_count, exp_txn);
    chk("rsp_valid_done", rsp_valid, 0);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rdata = '0; ready = 1'b0; rsp_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_valid", valid, 0);
    chk("rst_addr", addr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_timeout", rsp_timeout, 0);
    chk("rst_txn_count", txn_count, 0);

    // Echo slave: completes on first REQ cycle returning wdata.
    txn(4'hC, 4'hA, 4'hA, 0, 0, 1'b0);
    // Slave never answers: full timeout.
    txn(4'h3, 4'h5, 4'h9, 20, 0, 1'b0);
    // Answer on the last allowed cycle wins over timeout.
    txn(4'h7, 4'h1, 4'hE, TIMEOUT - 1, 0, 1'b0);
    txn(4'h2, 4'h4, 4'h6, TIMEOUT - 2, 0, 1'b0);
    // Downstream stalls the response for 5 cycles.
    txn(4'h8, 4'hB, 4'hD, 2, 5, 1'b0);
    txn(4'h9, 4'h2, 4'h0, 20, 3, 1'b0);

    // Random mix of delays, timeouts and response stalls.
    for (int i = 0; i < 40; i++)
      txn(4'($urandom), 4'($urandom), 4'($urandom),
          $urandom_range(0, 12), $urandom_range(0, 3), 1'b0);

    // 32 back-to-back single-cycle transactions: 3-cycle spacing, counter wraps.
    for (int i = 0; i < 32; i++)
      txn(4'($urandom), 4'($urandom), 4'($urandom), 0, 0, i > 0);

    // Reset in the middle of a request.
    cmd_valid = 1'b1; cmd_addr = 4'h5; cmd_wdata = 4'h6;
    @(negedge clk);
    cmd_valid = 1'b0; ready = 1'b0;
    @(negedge clk);
    chk("mid_valid_before", valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_valid_clear", valid, 0);
    chk("async_rsp_valid", rsp_valid, 0);
    chk("async_txn_count", txn_count, 0);
    @(negedge clk);
    rst = 1'b0;
    exp_txn = 0;
    @(negedge clk);
    chk("post_rst_cmd_ready", cmd_ready, 1);
    chk("post_rst_rsp_valid", rsp_valid, 0);
    chk("post_rst_addr", addr, 0);
    chk("post_rst_txn", txn_count, 0);
    @(negedge clk);
    chk("post_rst_no_rsp", rsp_valid, 0);
    // Block works normally again after the abandoned transaction.
    txn(4'hF, 4'h3, 4'h3, 1, 1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_cmd_master.md
BUS_CMD_MASTER -- requirements
Module: bus_cmd_master

Interface
REQ-001 Parameter TIMEOUT, default 8, meaning the number of REQ-state cycles without bus ready before the transaction is abandoned (legal range 2..15).
REQ-002 clock  input  1  single clock domain; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 cmd_valid  input  1  upstream command present.
REQ-005 cmd_ready  output  1  block can accept a command.
REQ-006 cmd_addr  input  4  target address.
REQ-007 cmd_wdata  input  4  write data.
REQ-008 valid  output  1  bus request, which connects to the slave valid.
REQ-009 addr  output  4  bus address.
REQ-010 wdata  output  4  bus write data.
REQ-011 rdata  input  4  bus read data from the slave.
REQ-012 ready  input  1  bus completion from the slave; it may be combinational on valid.
REQ-013 rsp_valid  output  1  response present.
REQ-014 rsp_ready  input  1  downstream accepts the response.
REQ-015 rsp_rdata  output  4  captured read data.
REQ-016 rsp_timeout  output  1  response was produced by timeout, not by ready.
REQ-017 txn_count  output  5  count of completed response handshakes.

Function
REQ-018 FSM states SHALL be IDLE, REQ and RESP, encoded in 2 bits; the unused encoding SHALL return to IDLE.
REQ-019 IDLE: cmd_ready=1 and valid=0; on cmd_valid&cmd_ready, cmd_addr and cmd_wdata SHALL be latched and the next state SHALL be REQ.
REQ-020 REQ: valid=1, addr/wdata SHALL equal the latched values and remain stable, and cmd_ready=0.
REQ-021 REQ with ready=1 sampled SHALL capture rdata into rsp_rdata, clear rsp_timeout and go to RESP next cycle.
REQ-022 REQ with ready=0 SHALL increment a wait counter (4 bits, cleared on entering REQ); when the counter equals TIMEOUT-1 and ready=0, next state SHALL be RESP with rsp_timeout=1 and rsp_rdata=4'h0.
REQ-023 ready sampled high on the same cycle that the counter reaches TIMEOUT-1 SHALL take precedence, giving a normal response.
REQ-024 RESP: rsp_valid=1, valid=0 and cmd_ready=0; rsp_rdata and rsp_timeout SHALL hold until rsp_valid&rsp_ready, then the next state SHALL be IDLE.
REQ-025 Latency: a command accepted at edge N SHALL drive valid in cycle N+1; with ready in that cycle, rsp_valid SHALL be asserted in cycle N+2.
REQ-026 Throughput: at most one outstanding transaction; back-to-back commands SHALL cost 3 cycles minimum each.
REQ-027 txn_count SHALL increment by 1 on each response handshake, including timeouts, and SHALL wrap from 31 to 0.
REQ-028 ready or rdata outside REQ SHALL be ignored.
REQ-029 All outputs SHALL be registered or decoded from state only; there is no combinational path from ready or rsp_ready to any output.

Reset
REQ-030 reset SHALL asynchronously force: state=IDLE, valid=0, addr=4'h0, wdata=4'h0, rsp_valid=0, rsp_rdata=4'h0, rsp_timeout=0, txn_count=0, wait counter=0.
REQ-031 Reset asserted mid-REQ or mid-RESP SHALL abandon the transaction with no response; cmd_ready=1 on the first cycle after deassertion.

Structure
REQ-032 A shared bus package SHALL hold the ADDR_W=4 and DATA_W=4 constants and the state enumeration (IDLE/REQ/RESP).
REQ-033 Single module; no sub-module; the timeout counter is inline.

Verification
REQ-034 After reset, cmd addr=4'hC, wdata=4'hA, with an echo slave (ready=valid, rdata=wdata) -> valid 1 cycle; rsp_rdata=4'hA and rsp_timeout=0 at N+2; txn_count=1.
REQ-035 ready held 0 with TIMEOUT=8 -> valid high exactly 8 cycles; then rsp_timeout=1 and rsp_rdata=4'h0.
REQ-036 ready first asserted on the 8th REQ cycle (TIMEOUT=8) -> normal response, rsp_timeout=0.
REQ-037 rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_rdata stable and cmd_ready=0 throughout; the next command is accepted only after the handshake.
REQ-038 32 back-to-back transactions -> txn_count wraps to 0; command spacing is 3 cycles each.
REQ-039 Reset pulsed during REQ -> valid=0 immediately (asynchronously); no rsp_valid; txn_count=0.
